fp_cvt_ws: RTL and testbench
============================

# fp_cvt_ws

Pipelined float32 → signed int32 converter (RISC-V FCVT.W.S semantics): the inverse of the existing int32 → float32 converter in the FP unit. Takes an IEEE-754 single-precision bit pattern plus a rounding mode and returns the rounded, saturated int32 with NV/NX exception flags. It sits in the FP execute path behind a valid/ready handshake, so the pipeline can stall on writeback backpressure.

## Interface

- No parameters.
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  input operand valid
- in_ready  out  1  converter can accept an operand this cycle
- in  in  32  float32 bit pattern
- rm  in  3  rounding mode: 000 RNE, 001 RTZ, 010 RDN, 011 RUP, 100 RMM; 101–111 treated as RTZ
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts the result this cycle
- res  out  32  signed int32 result
- nv  out  1  invalid flag (NaN, inf, out of range)
- nx  out  1  inexact flag

## Operation

- Three-stage pipeline. Each stage has a valid bit; all stages advance together when stall = out_valid & ~out_ready is low. in_ready = ~stall. An operand is accepted when in_valid & in_ready.
- S1 (unpack): capture sign, exp[7:0], frac[22:0], rm. Classify: NaN (exp=FF, frac≠0), inf (exp=FF, frac=0), zero/subnormal (exp=0; significand taken as 0.frac, never normalised). Normal significand is 1.frac (24 bits).
- S2 (align): e = exp − 127, signed 9 bits.
  - e < 0: mag = 0; guard = (e = −1 and normal); sticky = any remaining nonzero significand bits.
  - 0 ≤ e ≤ 23: mag = sig >> (23 − e); guard is the first bit shifted out; sticky is the OR of the remaining shifted-out bits.
  - 24 ≤ e ≤ 30: mag = sig << (e − 23); guard = sticky = 0.
  - e ≥ 31, NaN or inf: set the ovf marker. The only exception is sign=1, e=31, frac=0 (−2^31), which is exact and not ovf.
- S3 (round/pack):
  - Increment selection: RNE g&(s|mag[0]); RTZ 0; RDN sign&(g|s); RUP ~sign&(g|s); RMM g.
  - mag_r = mag + inc, 33 bits wide.
  - Positive: if ovf or mag_r > 0x7FFFFFFF, then res = 0x7FFFFFFF and nv = 1.
  - Negative: if ovf or mag_r > 0x80000000, then res = 0x80000000 and nv = 1. Otherwise res = −mag_r (two's complement).
  - NaN of either sign: res = 0x7FFFFFFF, nv = 1.
  - nx = (g|s) & ~nv. Flags are never both set.
- Signed zero (0x80000000 input) → res 0, no flags.

## Timing

- Latency: exactly 3 cycles from accept to out_valid with no stall. Throughput: 1 per cycle.
- While stalled, every stage register holds its value; res, nv and nx are stable while out_valid is high and out_ready is low.
- Simultaneous accept and drain in the same cycle is allowed with no bubble.
- Reset (async assert, synchronous-safe deassert): all stage valid bits are 0; out_valid = 0, res = 0, nv = 0, nx = 0; in_ready = 1 in the first cycle after release.
- Reset mid-operation discards every in-flight operand; no result from before reset ever appears.
- rm is sampled with in and travels in the pipeline. Changing rm later does not affect operands already in flight.

## Test plan

- Exact values, rm=RNE, out_ready=1:
  - 0x3F800000 → 0x00000001
  - 0xBF800000 → 0xFFFFFFFF
  - 0x4B800000 → 0x01000000
  - 0xCF000000 → 0x80000000
  - 0x00000000 and 0x80000000 → 0
  - All with nv=0, nx=0 and out_valid exactly 3 cycles after accept.
- Rounding:
  - 0x3FC00000 (1.5): RNE→2, RTZ→1, RDN→1, RUP→2, RMM→2.
  - 0x40200000 (2.5): RNE→2, RMM→3.
  - 0xBFC00000 (−1.5): RDN→0xFFFFFFFE, RUP→0xFFFFFFFF.
  - Every case above sets nx=1.
- Subnormal 0x00000001: RUP→1 nx=1; RDN→0 nx=1; RTZ→0 nx=1.
- Saturation, all with nv=1, nx=0:
  - 0x4F000000 (2^31) → 0x7FFFFFFF
  - 0x7F800000 → 0x7FFFFFFF
  - 0xFF800000 → 0x80000000
  - 0x7FC00000 → 0x7FFFFFFF
  - 0xFFC00000 → 0x7FFFFFFF
  - 0xCF000001 → 0x80000000
- Backpressure: stream 8 back-to-back operands; hold out_ready=0 for 5 cycles mid-stream. in_ready drops the same cycle the stall begins, results stay stable, and all 8 results emerge in order with none lost or duplicated.
- Reset mid-stream: assert rst_n=0 with 3 operands in flight. out_valid falls immediately, res/nv/nx read 0, and after release no stale result appears before a new accept plus 3 cycles.

Source files
------------

// File: rtl/fp_cvt_ws.sv
// Three-stage float32 -> signed int32 converter (FCVT.W.S semantics) with a
// valid/ready handshake; the whole pipeline freezes on output backpressure.
`timescale 1ns/1ps
module fp_cvt_ws (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in,
  input  logic [2:0]  rm,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] res,
  output logic        nv,
  output logic        nx
);

  localparam int unsigned WORD_W = 32;
  localparam int unsigned EXP_W  = 8;
  localparam int unsigned FRAC_W = 23;
  localparam int unsigned SIG_W  = FRAC_W + 1;
  localparam int unsigned RM_W   = 3;
  localparam int unsigned EXT_W  = 2 * SIG_W;

  localparam logic [RM_W-1:0] RM_RNE = 3'b000;
  localparam logic [RM_W-1:0] RM_RDN = 3'b010;
  localparam logic [RM_W-1:0] RM_RUP = 3'b011;
  localparam logic [RM_W-1:0] RM_RMM = 3'b100;

  localparam logic [EXP_W-1:0] EXP_BIAS   = 8'd127;
  localparam logic [EXP_W-1:0] EXP_HALF   = 8'd126;
  localparam logic [EXP_W-1:0] EXP_RSHIFT = 8'd150;
  localparam logic [EXP_W-1:0] EXP_LSHIFT = 8'd157;
  localparam logic [EXP_W-1:0] EXP_INTMIN = 8'd158;

  localparam logic [WORD_W-1:0] INT_MAX = 32'h7FFF_FFFF;
  localparam logic [WORD_W-1:0] INT_MIN = 32'h8000_0000;

  logic stall;
  logic advance;

  logic              s1_valid_q, s1_valid_d;
  logic              s1_sign_q,  s1_sign_d;
  logic [EXP_W-1:0]  s1_exp_q,   s1_exp_d;
  logic [FRAC_W-1:0] s1_frac_q,  s1_frac_d;
  logic [RM_W-1:0]   s1_rm_q,    s1_rm_d;
  logic              s1_nan_q,   s1_nan_d;
  logic              s1_inf_q,   s1_inf_d;

  logic              s2_valid_q, s2_valid_d;
  logic              s2_sign_q,  s2_sign_d;
  logic              s2_nan_q,   s2_nan_d;
  logic              s2_ovf_q,   s2_ovf_d;
  logic [WORD_W-1:0] s2_mag_q,   s2_mag_d;
  logic              s2_g_q,     s2_g_d;
  logic              s2_s_q,     s2_s_d;
  logic [RM_W-1:0]   s2_rm_q,    s2_rm_d;

  logic              out_valid_q, out_valid_d;
  logic [WORD_W-1:0] res_q,       res_d;
  logic              nv_q,        nv_d;
  logic              nx_q,        nx_d;

  logic [SIG_W-1:0]  al_sig;
  logic [4:0]        al_rsh;
  logic [2:0]        al_lsh;
  logic [EXT_W-1:0]  al_ext;
  logic [WORD_W-1:0] al_mag;
  logic              al_g;
  logic              al_s;
  logic              al_ovf;

  logic              rd_inc;
  logic [WORD_W:0]   rd_mag;
  logic [WORD_W-1:0] rd_res;
  logic              rd_nv;
  logic              rd_nx;

  assign stall     = out_valid_q & ~out_ready;
  assign advance   = ~stall;
  assign in_ready  = advance;
  assign out_valid = out_valid_q;
  assign res       = res_q;
  assign nv        = nv_q;
  assign nx        = nx_q;

  // S1: unpack fields and classify the special encodings
  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_sign_d  = s1_sign_q;
    s1_exp_d   = s1_exp_q;
    s1_frac_d  = s1_frac_q;
    s1_rm_d    = s1_rm_q;
    s1_nan_d   = s1_nan_q;
    s1_inf_d   = s1_inf_q;
    if (advance) begin
      s1_valid_d = in_valid;
      s1_sign_d  = in[31];
      s1_exp_d   = in[30:23];
      s1_frac_d  = in[22:0];
      s1_rm_d    = rm;
      s1_nan_d   = (&in[30:23]) & (|in[22:0]);
      s1_inf_d   = (&in[30:23]) & ~(|in[22:0]);
    end
  end

  // S2 datapath: place the significand relative to the binary point.
  // Exponent ranges are compared on the biased field (e = exp - 127).
  always_comb begin
    al_sig = {(|s1_exp_q), s1_frac_q};
    al_rsh = 5'(EXP_RSHIFT - s1_exp_q);
    al_lsh = 3'(s1_exp_q - EXP_RSHIFT);
    al_ext = {al_sig, {SIG_W{1'b0}}} >> al_rsh;
    al_mag = '0;
    al_g   = 1'b0;
    al_s   = 1'b0;
    al_ovf = 1'b0;
    if (s1_nan_q | s1_inf_q) begin
      al_ovf = 1'b1;
    end else if (s1_exp_q < EXP_BIAS) begin
      al_g = (s1_exp_q == EXP_HALF);
      al_s = (s1_exp_q == EXP_HALF) ? (|s1_frac_q) : (|al_sig);
    end else if (s1_exp_q <= EXP_RSHIFT) begin
      al_mag = WORD_W'(al_ext[EXT_W-1:SIG_W]);
      al_g   = al_ext[SIG_W-1];
      al_s   = |al_ext[SIG_W-2:0];
    end else if (s1_exp_q <= EXP_LSHIFT) begin
      al_mag = WORD_W'(al_sig) << al_lsh;
    end else if (s1_sign_q && (s1_exp_q == EXP_INTMIN) && (s1_frac_q == '0)) begin
      // -2^31 is the one exactly representable value at e = 31
      al_mag = INT_MIN;
    end else begin
      al_ovf = 1'b1;
    end
  end

  // S2 register load
  always_comb begin
    s2_valid_d = s2_valid_q;
    s2_sign_d  = s2_sign_q;
    s2_nan_d   = s2_nan_q;
    s2_ovf_d   = s2_ovf_q;
    s2_mag_d   = s2_mag_q;
    s2_g_d     = s2_g_q;
    s2_s_d     = s2_s_q;
    s2_rm_d    = s2_rm_q;
    if (advance) begin
      s2_valid_d = s1_valid_q;
      s2_sign_d  = s1_sign_q;
      s2_nan_d   = s1_nan_q;
      s2_ovf_d   = al_ovf;
      s2_mag_d   = al_mag;
      s2_g_d     = al_g;
      s2_s_d     = al_s;
      s2_rm_d    = s1_rm_q;
    end
  end

  // S3 datapath: round the magnitude, saturate and apply the sign
  always_comb begin
    case (s2_rm_q)
      RM_RNE:  rd_inc = s2_g_q & (s2_s_q | s2_mag_q[0]);
      RM_RDN:  rd_inc = s2_sign_q & (s2_g_q | s2_s_q);
      RM_RUP:  rd_inc = ~s2_sign_q & (s2_g_q | s2_s_q);
      RM_RMM:  rd_inc = s2_g_q;
      default: rd_inc = 1'b0;
    endcase
    rd_mag = {1'b0, s2_mag_q} + (WORD_W + 1)'(rd_inc);
    rd_res = '0;
    rd_nv  = 1'b0;
    if (s2_nan_q) begin
      rd_res = INT_MAX;
      rd_nv  = 1'b1;
    end else if (!s2_sign_q) begin
      if (s2_ovf_q || (rd_mag > {1'b0, INT_MAX})) begin
        rd_res = INT_MAX;
        rd_nv  = 1'b1;
      end else begin
        rd_res = rd_mag[WORD_W-1:0];
      end
    end else begin
      if (s2_ovf_q || (rd_mag > {1'b0, INT_MIN})) begin
        rd_res = INT_MIN;
        rd_nv  = 1'b1;
      end else begin
        rd_res = -rd_mag[WORD_W-1:0];
      end
    end
    rd_nx = (s2_g_q | s2_s_q) & ~rd_nv;
  end

  // S3 register load; bubbles leave zeros on the result bus
  always_comb begin
    out_valid_d = out_valid_q;
    res_d       = res_q;
    nv_d        = nv_q;
    nx_d        = nx_q;
    if (advance) begin
      out_valid_d = s2_valid_q;
      res_d       = s2_valid_q ? rd_res : '0;
      nv_d        = s2_valid_q & rd_nv;
      nx_d        = s2_valid_q & rd_nx;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q  <= 1'b0;
      s1_sign_q   <= 1'b0;
      s1_exp_q    <= '0;
      s1_frac_q   <= '0;
      s1_rm_q     <= '0;
      s1_nan_q    <= 1'b0;
      s1_inf_q    <= 1'b0;
      s2_valid_q  <= 1'b0;
      s2_sign_q   <= 1'b0;
      s2_nan_q    <= 1'b0;
      s2_ovf_q    <= 1'b0;
      s2_mag_q    <= '0;
      s2_g_q      <= 1'b0;
      s2_s_q      <= 1'b0;
      s2_rm_q     <= '0;
      out_valid_q <= 1'b0;
      res_q       <= '0;
      nv_q        <= 1'b0;
      nx_q        <= 1'b0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_sign_q   <= s1_sign_d;
      s1_exp_q    <= s1_exp_d;
      s1_frac_q   <= s1_frac_d;
      s1_rm_q     <= s1_rm_d;
      s1_nan_q    <= s1_nan_d;
      s1_inf_q    <= s1_inf_d;
      s2_valid_q  <= s2_valid_d;
      s2_sign_q   <= s2_sign_d;
      s2_nan_q    <= s2_nan_d;
      s2_ovf_q    <= s2_ovf_d;
      s2_mag_q    <= s2_mag_d;
      s2_g_q      <= s2_g_d;
      s2_s_q      <= s2_s_d;
      s2_rm_q     <= s2_rm_d;
      out_valid_q <= out_valid_d;
      res_q       <= res_d;
      nv_q        <= nv_d;
      nx_q        <= nx_d;
    end
  end

endmodule

// File: tb/tb_fp_cvt_ws.sv
// Directed-vector bench for fp_cvt_ws: an exact fixed-point reference model
// feeds a scoreboard that checks results, flags, latency and stall behaviour.
`timescale 1ns/1ps
module tb_fp_cvt_ws;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_data = '0;
  logic [2:0]  rm = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] res;
  logic        nv;
  logic        nx;

  int unsigned cyc = 0;
  int unsigned stall_cnt = 0;
  int unsigned n_pop = 0;
  int          checks = 0;
  int          errors = 0;

  typedef struct packed {
    logic [33:0] val;
    int unsigned acc_cyc;
    int unsigned acc_stall;
  } exp_t;

  exp_t exp_q[$];

  fp_cvt_ws dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in        (in_data),
    .rm        (rm),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .res       (res),
    .nv        (nv),
    .nx        (nx)
  );

  initial forever #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, req, $time);
    end
  endtask

  // Exact value as a fixed-point number with 150 fractional bits, then rounded
  // on the true remainder and range-checked against the int32 limits.
  function automatic logic [33:0] model(input logic [31:0] f, input logic [2:0] r);
    logic         sgn;
    logic [7:0]   ex;
    logic [22:0]  fr;
    logic [23:0]  sig;
    logic [287:0] v;
    logic [137:0] ip;
    logic [149:0] fp;
    logic [149:0] half;
    logic         up;
    logic         rnz;
    logic [138:0] m;
    logic [138:0] lim;
    sgn = f[31];
    ex  = f[30:23];
    fr  = f[22:0];
    if (ex == 8'hFF)
      return (fr != 0) ? {32'h7FFF_FFFF, 2'b10}
                       : {(sgn ? 32'h8000_0000 : 32'h7FFF_FFFF), 2'b10};
    sig  = {(ex != 8'd0), fr};
    v    = 288'(sig) << ((ex == 8'd0) ? 8'd1 : ex);
    ip   = v[287:150];
    fp   = v[149:0];
    half = '0;
    half[149] = 1'b1;
    rnz = (fp != '0);
    case (r)
      3'd0:    up = (fp > half) || ((fp == half) && ip[0]);
      3'd2:    up = sgn && rnz;
      3'd3:    up = !sgn && rnz;
      3'd4:    up = (fp >= half);
      default: up = 1'b0;
    endcase
    m   = {1'b0, ip} + 139'(up);
    lim = sgn ? 139'h8000_0000 : 139'h7FFF_FFFF;
    if (m > lim)
      return {(sgn ? 32'h8000_0000 : 32'h7FFF_FFFF), 2'b10};
    return {(sgn ? -m[31:0] : m[31:0]), 1'b0, rnz};
  endfunction

  // Scoreboard / protocol monitor, sampled on the falling edge
  initial begin
    exp_t        e;
    logic        prev_stall = 1'b0;
    logic [33:0] prev_out = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        exp_q.delete();
        prev_stall = 1'b0;
      end else begin
        chk("in_ready", 64'(in_ready), 64'(!(out_valid && !out_ready)));
        if (prev_stall)
          chk("stall_hold", 64'({out_valid, res, nv, nx}), 64'({1'b1, prev_out}));
        if (out_valid) begin
          if (exp_q.size() == 0) begin
            chk("spurious_out_valid", 64'(out_valid), 64'(0));
          end else if (out_ready) begin
            e = exp_q.pop_front();
            n_pop++;
            chk("res", 64'(res), 64'(e.val[33:2]));
            chk("nv", 64'(nv), 64'(e.val[1]));
            chk("nx", 64'(nx), 64'(e.val[0]));
            chk("flag_excl", 64'(nv & nx), 64'(0));
            chk("latency", 64'(cyc - e.acc_cyc), 64'(3 + stall_cnt - e.acc_stall));
          end
        end
        prev_stall = out_valid && !out_ready;
        prev_out   = {res, nv, nx};
        if (prev_stall) stall_cnt++;
        if (in_valid && in_ready) begin
          e.val       = model(in_data, rm);
          e.acc_cyc   = cyc;
          e.acc_stall = stall_cnt;
          exp_q.push_back(e);
        end
      end
    end
  end

  // Present one operand and hold it until accepted; returns at posedge+1
  task automatic drive_op(input logic [31:0] f, input logic [2:0] r);
    int n = 0;
    in_valid = 1'b1;
    in_data  = f;
    rm       = r;
    @(negedge clk);
    while (!in_ready && n < 50) begin
      n++;
      @(negedge clk);
    end
    chk("accept_timeout", 64'(in_ready), 64'(1));
    @(posedge clk);
    #1;
  endtask

  task automatic vec(input logic [31:0] f, input logic [2:0] r,
                     input logic [31:0] xr, input logic xnv, input logic xnx);
    chk($sformatf("model_%h_rm%0d", f, r), 64'(model(f, r)), 64'({xr, xnv, xnx}));
    drive_op(f, r);
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int n = 0;
    in_valid = 1'b0;
    while (exp_q.size() != 0 && n < 100) begin
      n++;
      @(posedge clk);
    end
    #1;
    chk("drain", 64'(exp_q.size()), 64'(0));
  endtask

  logic [31:0] bp_ops [8] = '{32'h3F80_0000, 32'h4020_0000, 32'hC060_0000, 32'h4B00_0001,
                              32'h3EFF_FFFF, 32'hC2F6_E979, 32'h4E80_0000, 32'h0040_0000};
  logic [2:0]  bp_rms [8] = '{3'd0, 3'd4, 3'd2, 3'd3, 3'd4, 3'd0, 3'd1, 3'd3};

  initial begin
    int unsigned pop0;
    #12;
    chk("rst_out_valid", 64'(out_valid), 64'(0));
    chk("rst_res", 64'(res), 64'(0));
    chk("rst_flags", 64'({nv, nx}), 64'(0));
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("in_ready_after_reset", 64'(in_ready), 64'(1));

    // exact conversions
    vec(32'h3F80_0000, 3'd0, 32'h0000_0001, 1'b0, 1'b0);
    vec(32'hBF80_0000, 3'd0, 32'hFFFF_FFFF, 1'b0, 1'b0);
    vec(32'h4B80_0000, 3'd0, 32'h0100_0000, 1'b0, 1'b0);
    vec(32'hCF00_0000, 3'd0, 32'h8000_0000, 1'b0, 1'b0);
    vec(32'h0000_0000, 3'd0, 32'h0000_0000, 1'b0, 1'b0);
    vec(32'h8000_0000, 3'd0, 32'h0000_0000, 1'b0, 1'b0);
    // rounding modes
    vec(32'h3FC0_0000, 3'd0, 32'h0000_0002, 1'b0, 1'b1);
    vec(32'h3FC0_0000, 3'd1, 32'h0000_0001, 1'b0, 1'b1);
    vec(32'h3FC0_0000, 3'd2, 32'h0000_0001, 1'b0, 1'b1);
    vec(32'h3FC0_0000, 3'd3, 32'h0000_0002, 1'b0, 1'b1);
    vec(32'h3FC0_0000, 3'd4, 32'h0000_0002, 1'b0, 1'b1);
    vec(32'h3FC0_0000, 3'd6, 32'h0000_0001, 1'b0, 1'b1);
    vec(32'h4020_0000, 3'd0, 32'h0000_0002, 1'b0, 1'b1);
    vec(32'h4020_0000, 3'd4, 32'h0000_0003, 1'b0, 1'b1);
    vec(32'hBFC0_0000, 3'd2, 32'hFFFF_FFFE, 1'b0, 1'b1);
    vec(32'hBFC0_0000, 3'd3, 32'hFFFF_FFFF, 1'b0, 1'b1);
    vec(32'h3F00_0000, 3'd0, 32'h0000_0000, 1'b0, 1'b1);
    vec(32'h3F00_0000, 3'd4, 32'h0000_0001, 1'b0, 1'b1);
    // subnormal
    vec(32'h0000_0001, 3'd3, 32'h0000_0001, 1'b0, 1'b1);
    vec(32'h0000_0001, 3'd2, 32'h0000_0000, 1'b0, 1'b1);
    vec(32'h0000_0001, 3'd1, 32'h0000_0000, 1'b0, 1'b1);
    vec(32'h8000_0001, 3'd2, 32'hFFFF_FFFF, 1'b0, 1'b1);
    // saturation and specials
    vec(32'h4F00_0000, 3'd0, 32'h7FFF_FFFF, 1'b1, 1'b0);
    vec(32'h7F80_0000, 3'd0, 32'h7FFF_FFFF, 1'b1, 1'b0);
    vec(32'hFF80_0000, 3'd0, 32'h8000_0000, 1'b1, 1'b0);
    vec(32'h7FC0_0000, 3'd0, 32'h7FFF_FFFF, 1'b1, 1'b0);
    vec(32'hFFC0_0000, 3'd0, 32'h7FFF_FFFF, 1'b1, 1'b0);
    vec(32'hCF00_0001, 3'd0, 32'h8000_0000, 1'b1, 1'b0);
    vec(32'h4EFF_FFFF, 3'd3, 32'h7FFF_FF80, 1'b0, 1'b0);
    drain();

    // backpressure: 8 back-to-back operands, 5-cycle stall mid-stream
    pop0 = n_pop;
    fork
      begin
        for (int i = 0; i < 8; i++) drive_op(bp_ops[i], bp_rms[i]);
        in_valid = 1'b0;
      end
      begin
        repeat (4) @(posedge clk);
        #1 out_ready = 1'b0;
        repeat (5) @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    drain();
    chk("bp_count", 64'(n_pop - pop0), 64'(8));

    // reset with three operands in flight
    out_ready = 1'b0;
    drive_op(32'h3FC0_0000, 3'd0);
    drive_op(32'hBF80_0000, 3'd0);
    drive_op(32'h7F80_0000, 3'd0);
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", 64'(out_valid), 64'(0));
    chk("midrst_res", 64'(res), 64'(0));
    chk("midrst_flags", 64'({nv, nx}), 64'(0));
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("postrst_in_ready", 64'(in_ready), 64'(1));
    for (int i = 0; i < 6; i++) begin
      chk("postrst_no_stale", 64'(out_valid), 64'(0));
      @(posedge clk);
      #1;
    end
    vec(32'h4020_0000, 3'd3, 32'h0000_0003, 1'b0, 1'b1);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
